// File: rtl/pcpi_arbiter.sv
// Two-requester round-robin front end for a single PCPI coprocessor.
// Optional abort timeout enabled by defining PCPI_ARB_TIMEOUT_EN.
module pcpi_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [31:0] req0_insn,
   input  logic [31:0] req0_rs1,
   input  logic [31:0] req0_rs2,
   input  logic        req1_valid,
   input  logic [31:0] req1_insn,
   input  logic [31:0] req1_rs1,
   input  logic [31:0] req1_rs2,
   output logic        req0_done,
   output logic        req1_done,
   output logic [31:0] rsp_rd,
   output logic        rsp_wr,
   output logic        rsp_err,
   output logic        grant,
   output logic        pcpi_valid,
   output logic [31:0] pcpi_insn,
   output logic [31:0] pcpi_rs1,
   output logic [31:0] pcpi_rs2,
   input  logic        pcpi_ready,
   input  logic        pcpi_wr,
   input  logic [31:0] pcpi_rd,
   input  logic        pcpi_wait
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 2..255");
   end

   state_t state;
   logic   last;
   logic   win;

   // Tie goes to the requester not granted last time
   always_comb begin
      win = req1_valid;
      if (req0_valid && req1_valid)
         win = ~last;
   end

`ifdef PCPI_ARB_TIMEOUT_EN
   localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt;
`else
   logic unused_wait;
   assign unused_wait = pcpi_wait;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last       <= 1'b1;
         grant      <= 1'b0;
         pcpi_valid <= 1'b0;
         pcpi_insn  <= '0;
         pcpi_rs1   <= '0;
         pcpi_rs2   <= '0;
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
         rsp_rd     <= '0;
         rsp_wr     <= 1'b0;
         rsp_err    <= 1'b0;
`ifdef PCPI_ARB_TIMEOUT_EN
         cnt        <= '0;
`endif
      end else begin
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  grant      <= win;
                  last       <= win;
                  pcpi_valid <= 1'b1;
                  pcpi_insn  <= win ? req1_insn : req0_insn;
                  pcpi_rs1   <= win ? req1_rs1 : req0_rs1;
                  pcpi_rs2   <= win ? req1_rs2 : req0_rs2;
`ifdef PCPI_ARB_TIMEOUT_EN
                  cnt        <= '0;
`endif
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (pcpi_ready) begin
                  rsp_rd     <= pcpi_rd;
                  rsp_wr     <= pcpi_wr;
                  rsp_err    <= 1'b0;
                  pcpi_valid <= 1'b0;
                  req0_done  <= ~grant;
                  req1_done  <= grant;
                  state      <= DONE;
               end
`ifdef PCPI_ARB_TIMEOUT_EN
               else if (pcpi_wait) begin
                  cnt <= '0;
               end else if (cnt == TMAX) begin
                  rsp_rd     <= '0;
                  rsp_wr     <= 1'b0;
                  rsp_err    <= 1'b1;
                  pcpi_valid <= 1'b0;
                  req0_done  <= ~grant;
                  req1_done  <= grant;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
`endif
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcpi_arbiter.sv
// Randomized and directed bench for pcpi_arbiter against a round-robin model.
// Timeout scenarios run only when PCPI_ARB_TIMEOUT_EN is defined.
module tb_pcpi_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_insn, req0_rs1, req0_rs2;
   logic [31:0] req1_insn, req1_rs1, req1_rs2;
   logic        req0_done, req1_done;
   logic [31:0] rsp_rd;
   logic        rsp_wr, rsp_err, grant, pcpi_valid;
   logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic        pcpi_ready, pcpi_wr, pcpi_wait;
   logic [31:0] pcpi_rd;

   int checks = 0;
   int errors = 0;
   int last_gnt;
   logic [31:0] exp_rd;
   logic        exp_wr;

   always #5 clk = ~clk;

   pcpi_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_insn(req0_insn),
      .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
      .req1_valid(req1_valid), .req1_insn(req1_insn),
      .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
      .req0_done(req0_done), .req1_done(req1_done),
      .rsp_rd(rsp_rd), .rsp_wr(rsp_wr), .rsp_err(rsp_err),
      .grant(grant), .pcpi_valid(pcpi_valid),
      .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
      .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr),
      .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " pcpi_valid"}, 32'(pcpi_valid), 32'd0);
      chk({tag, " done0"}, 32'(req0_done), 32'd0);
      chk({tag, " done1"}, 32'(req1_done), 32'd0);
      chk({tag, " grant"}, 32'(grant), 32'd0);
      chk({tag, " rsp_rd"}, rsp_rd, 32'd0);
      chk({tag, " rsp_wr"}, 32'(rsp_wr), 32'd0);
      chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
      chk({tag, " insn"}, pcpi_insn, 32'd0);
      chk({tag, " rs1"}, pcpi_rs1, 32'd0);
      chk({tag, " rs2"}, pcpi_rs2, 32'd0);
   endtask

   task automatic load0();
      req0_valid = 1'b1;
      req0_insn = $urandom;
      req0_rs1 = $urandom;
      req0_rs2 = $urandom;
   endtask

   task automatic load1();
      req1_valid = 1'b1;
      req1_insn = $urandom;
      req1_rs1 = $urandom;
      req1_rs2 = $urandom;
   endtask

   // Called in IDLE with at least one request pending; returns in IDLE.
   task automatic serve(input int delay, input logic [31:0] rd,
                        input logic wr);
      int w;
      logic [31:0] ei, e1, e2;
      if (req0_valid && req1_valid) w = 1 - last_gnt;
      else w = req1_valid ? 1 : 0;
      ei = (w == 1) ? req1_insn : req0_insn;
      e1 = (w == 1) ? req1_rs1 : req0_rs1;
      e2 = (w == 1) ? req1_rs2 : req0_rs2;
      last_gnt = w;
      step();
      chk("grant", 32'(grant), 32'(w));
      chk("busy valid", 32'(pcpi_valid), 32'd1);
      chk("busy insn", pcpi_insn, ei);
      chk("busy rs1", pcpi_rs1, e1);
      chk("busy rs2", pcpi_rs2, e2);
      for (int i = 0; i < delay; i++) begin
         pcpi_rd = $urandom;
         pcpi_wr = 1'($urandom);
         pcpi_wait = 1'($urandom);
         step();
         chk("hold valid", 32'(pcpi_valid), 32'd1);
         chk("hold insn", pcpi_insn, ei);
         chk("hold rs1", pcpi_rs1, e1);
         chk("hold rs2", pcpi_rs2, e2);
         chk("hold done", {30'd0, req1_done, req0_done}, 32'd0);
      end
      pcpi_wait = 1'b0;
      pcpi_ready = 1'b1;
      pcpi_rd = rd;
      pcpi_wr = wr;
      step();
      pcpi_ready = 1'b0;
      pcpi_rd = $urandom;
      pcpi_wr = 1'($urandom);
      exp_rd = rd;
      exp_wr = wr;
      chk("done0", 32'(req0_done), 32'(w == 0));
      chk("done1", 32'(req1_done), 32'(w == 1));
      chk("rsp_rd", rsp_rd, exp_rd);
      chk("rsp_wr", 32'(rsp_wr), 32'(exp_wr));
      chk("rsp_err", 32'(rsp_err), 32'd0);
      chk("done valid", 32'(pcpi_valid), 32'd0);
      if (w == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
      step();
      chk("done width", {30'd0, req1_done, req0_done}, 32'd0);
      chk("rsp_rd hold", rsp_rd, exp_rd);
      chk("rsp_wr hold", 32'(rsp_wr), 32'(exp_wr));
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_insn = '0; req0_rs1 = '0; req0_rs2 = '0;
      req1_insn = '0; req1_rs1 = '0; req1_rs2 = '0;
      pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0;
      last_gnt = 1;
      exp_rd = '0;
      exp_wr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset = 1'b0;
      step();

      // Simultaneous pairs after reset: 0, then 1, then 0 again
      load0(); load1();
      serve(0, $urandom, 1'b1);
      chk("pair1 winner", 32'(last_gnt), 32'd0);
      serve(1, $urandom, 1'b0);
      load0(); load1();
      serve(2, $urandom, 1'b1);
      chk("pair3 winner", 32'(last_gnt), 32'd0);
      serve(0, $urandom, 1'b1);

      // Lone req0, minimum latency
      req0_valid = 1'b1;
      req0_insn = 32'h0200_0033;
      req0_rs1 = 32'd3;
      req0_rs2 = 32'd5;
      serve(0, 32'd15, 1'b1);

      // Slow coprocessor
      load1();
      serve(10, $urandom, 1'b1);

      // Ready outside BUSY is ignored
      pcpi_ready = 1'b1;
      pcpi_wr = 1'b1;
      pcpi_rd = 32'hdead_beef;
      repeat (3) begin
         step();
         chk("idle done", {30'd0, req1_done, req0_done}, 32'd0);
         chk("idle valid", 32'(pcpi_valid), 32'd0);
         chk("idle rsp_rd", rsp_rd, exp_rd);
         chk("idle grant", 32'(grant), 32'(last_gnt));
      end
      pcpi_ready = 1'b0;
      pcpi_wr = 1'b0;

      // Random traffic
      for (int n = 0; n < 150; n++) begin
         if (!req0_valid && ($urandom_range(1, 0) == 1)) load0();
         if (!req1_valid && ($urandom_range(1, 0) == 1)) load1();
         if (!req0_valid && !req1_valid) load1();
         serve($urandom_range(6, 0), $urandom, 1'($urandom));
      end
      for (int k = 0; k < 2; k++)
         if (req0_valid || req1_valid) serve(0, $urandom, 1'b1);

`ifdef PCPI_ARB_TIMEOUT_EN
      // Abort after 16 silent BUSY cycles
      load1();
      last_gnt = 1;
      step();
      chk("to grant", 32'(grant), 32'd1);
      repeat (15) begin
         step();
         chk("to wait done", 32'(req1_done), 32'd0);
         chk("to wait valid", 32'(pcpi_valid), 32'd1);
      end
      step();
      chk("to done1", 32'(req1_done), 32'd1);
      chk("to done0", 32'(req0_done), 32'd0);
      chk("to err", 32'(rsp_err), 32'd1);
      chk("to rd", rsp_rd, 32'd0);
      chk("to wr", 32'(rsp_wr), 32'd0);
      chk("to valid", 32'(pcpi_valid), 32'd0);
      req1_valid = 1'b0;
      step();
      chk("to width", 32'(req1_done), 32'd0);

      // Wait holds off the abort indefinitely
      load0();
      last_gnt = 0;
      step();
      pcpi_wait = 1'b1;
      repeat (40) begin
         step();
         chk("wait done", 32'(req0_done), 32'd0);
         chk("wait valid", 32'(pcpi_valid), 32'd1);
      end
      pcpi_wait = 1'b0;
      pcpi_ready = 1'b1;
      pcpi_rd = 32'h1234_5678;
      pcpi_wr = 1'b1;
      step();
      pcpi_ready = 1'b0;
      exp_rd = 32'h1234_5678;
      exp_wr = 1'b1;
      chk("wait done0", 32'(req0_done), 32'd1);
      chk("wait err", 32'(rsp_err), 32'd0);
      chk("wait rd", rsp_rd, exp_rd);
      req0_valid = 1'b0;
      step();
`endif

      // Reset in the middle of BUSY
      load0();
      step();
      chk("pre-reset valid", 32'(pcpi_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk_all_zero("mid reset");
      req0_valid = 1'b0;
      step();
      chk("reset no done", {30'd0, req1_done, req0_done}, 32'd0);
      reset = 1'b0;
      last_gnt = 1;
      exp_rd = '0;
      exp_wr = 1'b0;
      step();
      chk("post-reset done", {30'd0, req1_done, req0_done}, 32'd0);
      load1();
      serve(3, $urandom, 1'b1);
      chk("post-reset winner", 32'(last_gnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcpi_arbiter.md
PCPI_ARBITER -- requirements
Module: pcpi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning coprocessor cycles (without pcpi_wait) before abort; legal range 2..255.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- req0_valid / req1_valid  in  1  requester N has a command pending
- req0_insn / req1_insn  in  32  requester N instruction word
- req0_rs1 / req1_rs1  in  32  requester N operand 1
- req0_rs2 / req1_rs2  in  32  requester N operand 2
- req0_done / req1_done  out  1  one-cycle completion pulse to requester N
- rsp_rd  out  32  shared result bus, valid while any reqN_done is high
- rsp_wr  out  1  result write-back flag, valid with done
- rsp_err  out  1  command aborted by timeout, valid with done
- grant  out  1  index of the requester currently owning the coprocessor
- pcpi_valid  out  1  command valid to coprocessor
- pcpi_insn / pcpi_rs1 / pcpi_rs2  out  32  command to coprocessor
- pcpi_ready  in  1  coprocessor finished
- pcpi_wr  in  1  coprocessor result write-back flag
- pcpi_rd  in  32  coprocessor result
- pcpi_wait  in  1  coprocessor still working; suspends timeout

Function
REQ-004 SHALL implement states IDLE, BUSY, DONE; all outputs registered.
REQ-005 IDLE: if any reqN_valid is sampled high, SHALL select a winner, latch its insn/rs1/rs2 into pcpi_insn/rs1/rs2, set grant, assert pcpi_valid, and enter BUSY on the same edge.
REQ-006 Arbitration SHALL be round-robin: a requester granted last loses a tie; a lone request always wins.
REQ-007 BUSY: pcpi_valid and pcpi_insn/rs1/rs2 SHALL stay stable until pcpi_ready is sampled high.
REQ-008 On pcpi_ready in BUSY, SHALL capture pcpi_rd→rsp_rd and pcpi_wr→rsp_wr, clear rsp_err, deassert pcpi_valid, pulse done[grant], and enter DONE.
REQ-009 DONE SHALL last exactly one cycle; done drops and the state returns to IDLE. rsp_rd/rsp_wr/rsp_err hold until the next completion.
REQ-010 Minimum latency: reqN_valid high in cycle 0 gives pcpi_valid in cycle 1; pcpi_ready in cycle 1 gives reqN_done in cycle 2.
REQ-011 Requesters SHALL hold valid and data stable until their done pulse and drop valid in the following cycle. Deassertion of valid before done is ignored; the command completes anyway.
REQ-012 pcpi_ready, pcpi_wr and pcpi_rd SHALL be ignored outside BUSY.
REQ-013 grant SHALL change only on an IDLE→BUSY transition.

Reset
REQ-014 Reset SHALL force:
- state to IDLE
- pcpi_valid, req0_done, req1_done, rsp_wr, rsp_err, grant and every 32-bit output to 0
- the round-robin pointer so that requester 0 wins the first tie
- the timeout counter to 0
REQ-015 Reset asserted in BUSY or DONE SHALL abandon the command with no done pulse. The first post-reset arbitration follows REQ-005.

Configuration
REQ-016 Macro PCPI_ARB_TIMEOUT_EN defined: in BUSY, an 8-bit counter SHALL work as follows:
- increments each cycle pcpi_ready=0 and pcpi_wait=0
- clears while pcpi_wait=1
- clears on entry to BUSY
REQ-017 With PCPI_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES-1 with pcpi_ready low, the next edge SHALL deassert pcpi_valid, set rsp_rd=0, rsp_wr=0, rsp_err=1, pulse done[grant], and enter DONE. If pcpi_ready and expiry coincide, pcpi_ready wins with rsp_err=0.
REQ-018 Macro undefined: no counter; rsp_err is constant 0; BUSY waits indefinitely for pcpi_ready.

Verification
REQ-019 Bench SHALL cover:
- req0 alone with insn=0x0200_0033, rs1=3, rs2=5; ready with rd=15, wr=1 in first BUSY cycle → req0_done in cycle 2, rsp_rd=15, rsp_wr=1, rsp_err=0.
- req0 and req1 simultaneous right after reset → req0 served first, grant=0; req1 next with grant=1. A further simultaneous pair → req0 served first again.
- Coprocessor delays ready 10 cycles → pcpi_valid and pcpi_insn/rs1/rs2 stable all 10 cycles, done exactly one cycle.
- PCPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ready, no wait → done after 16 BUSY cycles, rsp_err=1, rsp_rd=0. With pcpi_wait high → no abort.
- Reset pulsed mid-BUSY → all outputs 0 immediately, no done pulse; next req1-only request is granted.
- pcpi_ready pulsed in IDLE → no done, no state change.
